// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: zero/sign/LUI/scaled-sign extension with a
// 2-entry skid buffer so in_ready is a pure register output.
module imm_ext_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    if (OUT_W < 2*IN_W || IN_W < 2) begin : g_param_check
        $error("imm_ext_pipe: need IN_W >= 2 and OUT_W >= 2*IN_W");
    end

    // State encodes {main valid, skid valid}; (0,1) cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic signed [OUT_W-1:0] sx;
        sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            2'b00:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b01:   extend = sx;
            2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
            default: extend = sx <<< 1;
        endcase
    endfunction

    state_t           state_p1;
    logic [OUT_W-1:0] ext_p0;
    logic [OUT_W-1:0] k_data_p1;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // ---- p0: extension computed at the input transfer ----
    always_comb begin
        ext_p0 = extend(in_imm, in_mode);
    end

    // ---- p1: main register drives outputs, skid register absorbs one stall ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1  <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_neg   <= 1'b0;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (in_xfer) begin
                        state_p1  <= ONE;
                        out_valid <= 1'b1;
                        out_data  <= ext_p0;
                        out_neg   <= ext_p0[OUT_W-1];
                    end
                end
                ONE: begin
                    if (out_xfer && !in_xfer) begin
                        state_p1  <= EMPTY;
                        out_valid <= 1'b0;
                    end else if (out_xfer && in_xfer) begin
                        out_data  <= ext_p0;
                        out_neg   <= ext_p0[OUT_W-1];
                    end else if (in_xfer) begin
                        state_p1  <= FULL;
                        in_ready  <= 1'b0;
                        k_data_p1 <= ext_p0;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_p1  <= ONE;
                        in_ready  <= 1'b1;
                        out_data  <= k_data_p1;
                        out_neg   <= k_data_p1[OUT_W-1];
                    end
                end
                default: begin
                    state_p1  <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
